// File: rtl/note_line_fetcher_if.sv
// Bus bundle between the note-glyph line fetcher and its code memory, glyph ROM and pixel mapper.
// master = fetcher side, slave = memories / video timing side.
interface note_line_fetcher_if #(
  parameter int COL_W = 5
);
  logic             line_start;
  logic [2:0]       line_y;
  logic [COL_W-1:0] code_addr;
  logic [7:0]       code_data;
  logic [7:0]       rom_addr;
  logic [7:0]       rom_data;
  logic [COL_W+2:0] pix_x;
  logic             pix_out;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    input  line_start, line_y, code_data, rom_data, pix_x,
    output code_addr, rom_addr, pix_out, busy, done, overrun
  );

  modport slave (
    output line_start, line_y, code_data, rom_data, pix_x,
    input  code_addr, rom_addr, pix_out, busy, done, overrun
  );
endinterface

// File: rtl/note_line_fetcher.sv
// Per-scanline note-glyph fetcher: code memory -> glyph ROM -> double-buffered line buffer -> pixels.
// Optional NOTE_HILITE_EN: code bit7 marks a highlighted note, written as inverse video.
//
// state | meaning
// IDLE  | waiting for line_start, addresses hold
// RUN   | cycle k issues code_addr=k, writes column k-1 into back buffer
// DONE  | one-cycle done pulse, back buffer complete
module note_line_fetcher #(
  parameter int NUM_COLS = 32,
  parameter int COL_W    = 5
) (
  input logic               clk,
  input logic               rst,
  note_line_fetcher_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [COL_W:0]   K_LAST  = (COL_W+1)'(NUM_COLS);
  localparam logic [COL_W:0]   K_ONE   = (COL_W+1)'(1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  state_t           state;
  logic [COL_W:0]   k;
  logic [2:0]       y;
  logic             front_sel;
  logic [7:0]       buf0 [NUM_COLS];
  logic [7:0]       buf1 [NUM_COLS];
  logic [COL_W-1:0] code_addr_q;
  logic [7:0]       rom_addr_q;
  logic             pix_out_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;

  logic             blank;
  logic [4:0]       eff_code;
  logic [7:0]       rom_addr_c;
  logic [7:0]       row_wr;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [COL_W-1:0] pcol;
  logic [2:0]       pbit;
  logic [7:0]       front_row;

`ifdef NOTE_HILITE_EN
  assign blank  = |bus.code_data[6:5];
  assign row_wr = bus.code_data[7] ? ~bus.rom_data : bus.rom_data;
`else
  assign blank  = |bus.code_data[7:5];
  assign row_wr = bus.rom_data;
`endif

  assign eff_code   = blank ? 5'd0 : bus.code_data[4:0];
  assign rom_addr_c = {eff_code, y};
  assign wr_en      = (state == RUN) && (k != '0);
  assign wr_col     = k[COL_W-1:0] - COL_ONE;

  // front_sel=1 shows buf1 and fills buf0; the two never alias
  assign pcol      = bus.pix_x[COL_W+2:3];
  assign pbit      = 3'd7 - bus.pix_x[2:0];
  assign front_row = front_sel ? buf1[pcol] : buf0[pcol];

  assign bus.code_addr = code_addr_q;
  assign bus.rom_addr  = wr_en ? rom_addr_c : rom_addr_q;
  assign bus.pix_out   = pix_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      y           <= '0;
      front_sel   <= 1'b0;
      code_addr_q <= '0;
      rom_addr_q  <= '0;
      pix_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        buf0[i] <= '0;
        buf1[i] <= '0;
      end
    end else begin
      pix_out_q <= front_row[pbit];
      done_q    <= 1'b0;
      if (bus.line_start) begin
        // a restart while busy drops the in-flight column write and exposes the partial line
        if (state != IDLE) overrun_q <= 1'b1;
        y           <= bus.line_y;
        front_sel   <= ~front_sel;
        k           <= '0;
        code_addr_q <= '0;
        busy_q      <= 1'b1;
        state       <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (wr_en) begin
              rom_addr_q <= rom_addr_c;
              if (front_sel) buf0[wr_col] <= row_wr;
              else           buf1[wr_col] <= row_wr;
            end
            if (code_addr_q != {COL_W{1'b1}}) code_addr_q <= code_addr_q + COL_ONE;
            if (k == K_LAST) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              k <= k + K_ONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_line_fetcher.sv
// Self-checking bench for note_line_fetcher: vector table of glyph lines, pixel scoreboard,
// abort/overrun and reset-mid-fetch sequences.
module tb_note_line_fetcher;

  localparam int NUM_COLS = 32;
  localparam int COL_W    = 5;

  logic clk;
  logic rst;
  note_line_fetcher_if #(.COL_W(COL_W)) bus ();

  note_line_fetcher #(.NUM_COLS(NUM_COLS), .COL_W(COL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] fill;
    int         col;
    logic [7:0] code;
    logic [2:0] y;
    int         chk_col;
    logic [7:0] exp_row;
  } vec_t;

  logic [7:0] cmem [NUM_COLS];
  logic [7:0] mbuf [2][NUM_COLS];
  logic       mfront;
  logic       pq [$];
  int         n_checks;
  int         n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // glyph ROM contents; blank codes and code 0 read as zero
  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    logic [4:0] c;
    logic [2:0] r;
    c = a[7:3];
    r = a[2:0];
    if (c == 5'h00 || (c >= 5'h0D && c <= 5'h0F) || c >= 5'h1A) return 8'h00;
    if (c == 5'h01) return 8'hFF;
    if (c == 5'h02 && r == 3'd3) return 8'h81;
    if (c == 5'h18 && r == 3'd2) return 8'h26;
    if (c == 5'h05 && r == 3'd0) return 8'h41;
    return (a * 8'd29) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] exp_raddr(input logic [7:0] cd, input logic [2:0] yy);
    logic blank;
`ifdef NOTE_HILITE_EN
    blank = (cd[6:5] != 2'b00);
`else
    blank = (cd[7:5] != 3'b000);
`endif
    return {blank ? 5'd0 : cd[4:0], yy};
  endfunction

  function automatic logic [7:0] exp_row(input logic [7:0] cd, input logic [2:0] yy);
    logic [7:0] r;
    r = rom_fn(exp_raddr(cd, yy));
`ifdef NOTE_HILITE_EN
    if (cd[7]) r = ~r;
`endif
    return r;
  endfunction

  always @(posedge clk) bus.code_data <= cmem[bus.code_addr];
  assign bus.rom_data = rom_fn(bus.rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pulse_ls(input logic [2:0] yy);
    @(posedge clk);
    #1;
    bus.line_start = 1'b1;
    bus.line_y     = yy;
    @(posedge clk);
    #1;
    bus.line_start = 1'b0;
  endtask

  task automatic model_swap(input logic [2:0] yy);
    mfront = ~mfront;
    for (int c = 0; c < NUM_COLS; c++) mbuf[~mfront][c] = exp_row(cmem[c], yy);
  endtask

  task automatic check_fetch(input logic [2:0] yy);
    for (int k = 0; k <= NUM_COLS; k++) begin
      @(negedge clk);
      chk("busy_run", 32'(bus.busy), 1);
      chk("done_early", 32'(bus.done), 0);
      chk("code_addr", 32'(bus.code_addr), (k < NUM_COLS) ? k : NUM_COLS - 1);
      if (k >= 1) chk("rom_addr", 32'(bus.rom_addr), 32'(exp_raddr(cmem[k-1], yy)));
    end
    @(negedge clk);
    chk("done", 32'(bus.done), 1);
    chk("busy_done", 32'(bus.busy), 0);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 0);
    chk("code_addr_hold", 32'(bus.code_addr), NUM_COLS - 1);
    chk("rom_addr_hold", 32'(bus.rom_addr), 32'(exp_raddr(cmem[NUM_COLS-1], yy)));
  endtask

  task automatic do_line(input logic [2:0] yy);
    pulse_ls(yy);
    model_swap(yy);
    check_fetch(yy);
  endtask

  // drive pix_x, push expected bit; compare one edge later
  task automatic scan(input int x0, input int n, input bit use_c, input logic [7:0] crow, input string nm);
    int x;
    logic e;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        e = pq.pop_front();
        chk(nm, 32'(bus.pix_out), 32'(e));
      end
      if (i < n) begin
        x = x0 + i;
        bus.pix_x = x[COL_W+2:0];
        if (use_c) pq.push_back(crow[7 - (x % 8)]);
        else       pq.push_back(mbuf[mfront][x / 8][7 - (x % 8)]);
      end
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_code_addr"}, 32'(bus.code_addr), 0);
    chk({nm, "_rom_addr"},  32'(bus.rom_addr), 0);
    chk({nm, "_pix_out"},   32'(bus.pix_out), 0);
    chk({nm, "_busy"},      32'(bus.busy), 0);
    chk({nm, "_done"},      32'(bus.done), 0);
    chk({nm, "_overrun"},   32'(bus.overrun), 0);
  endtask

  task automatic model_reset();
    mfront = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      mbuf[0][c] = 8'h00;
      mbuf[1][c] = 8'h00;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    vecs[0] = '{8'h01, 0,  8'h01, 3'd3, 0,  8'hFF};
    vecs[1] = '{8'h01, 0,  8'h01, 3'd3, 17, 8'hFF};
    vecs[2] = '{8'h00, 5,  8'h02, 3'd3, 5,  8'h81};
    vecs[3] = '{8'h00, 5,  8'h02, 3'd3, 4,  8'h00};
`ifdef NOTE_HILITE_EN
    vecs[4] = '{8'h00, 0,  8'h85, 3'd0, 0,  8'hBE};
`else
    vecs[4] = '{8'h00, 0,  8'h25, 3'd0, 0,  8'h00};
`endif
    vecs[5] = '{8'h00, 31, 8'h18, 3'd2, 31, 8'h26};
    vecs[6] = '{8'h00, 31, 8'h18, 3'd2, 0,  8'h00};
    vecs[7] = '{8'h00, 7,  8'h0D, 3'd1, 7,  8'h00};
    vecs[8] = '{8'h00, 3,  8'h1F, 3'd4, 3,  8'h00};

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.line_start = 1'b0;
    bus.line_y = 3'd0;
    bus.pix_x = '0;
    for (int c = 0; c < NUM_COLS; c++) cmem[c] = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    scan(0, 256, 1'b0, 8'h00, "pix_after_reset");

    foreach (vecs[v]) begin
      for (int c = 0; c < NUM_COLS; c++) cmem[c] = vecs[v].fill;
      cmem[vecs[v].col] = vecs[v].code;
      do_line(vecs[v].y);
      do_line(vecs[v].y ^ 3'd5);
      scan(vecs[v].chk_col * 8, 8, 1'b1, vecs[v].exp_row, "vec_row");
      scan(0, 256, 1'b0, 8'h00, "vec_line");
    end

    for (int c = 0; c < NUM_COLS; c++) cmem[c] = 8'($urandom);
    do_line(3'd6);
    do_line(3'd1);
    scan(0, 256, 1'b0, 8'h00, "rand_line");
    chk("overrun_clear", 32'(bus.overrun), 0);

    // restart 12 cycles into a fetch
    for (int c = 0; c < NUM_COLS; c++) cmem[c] = 8'($urandom);
    pulse_ls(3'd1);
    mfront = ~mfront;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 0);
      chk("abort_busy", 32'(bus.busy), 1);
      @(posedge clk);
    end
    pulse_ls(3'd6);
    chk("overrun_set", 32'(bus.overrun), 1);
    model_swap(3'd6);
    check_fetch(3'd6);
    do_line(3'd2);
    scan(0, 256, 1'b0, 8'h00, "restart_line");
    chk("overrun_sticky", 32'(bus.overrun), 1);

    // asynchronous reset at column 10 of a fetch
    pulse_ls(3'd5);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_col", 32'(bus.code_addr), 10);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid_run");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    scan(0, 256, 1'b0, 8'h00, "pix_mid_reset");
    for (int c = 0; c < NUM_COLS; c++) cmem[c] = 8'($urandom);
    do_line(3'd3);
    do_line(3'd0);
    scan(0, 256, 1'b0, 8'h00, "post_reset_line");
    chk("overrun_after_reset", 32'(bus.overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
